// File: rtl/cpu_pkg.sv
// Shared types and encodings for the instruction controller and its decoder.
package cpu_pkg;

    typedef enum logic [2:0] {
        S_WAIT, S_DECODE, S_WRITE_IMM, S_GET_A, S_GET_B, S_ALU, S_CMP, S_WRITE_REG
    } state_t;

    typedef enum logic [2:0] {
        IC_UNDEF, IC_MOVI, IC_MOVR, IC_ADD, IC_CMP, IC_AND, IC_MVN
    } iclass_t;

    typedef logic [2:0] regsel_t;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOVI = 2'b10;
    localparam logic [1:0] OP_MOVR = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_CMP  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_MVN  = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;

endpackage

// File: rtl/instr_decoder.sv
// Combinational split of the instruction register into fields and an instruction class.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [15:0] i_ir,
    output regsel_t     o_rn,
    output regsel_t     o_rd,
    output regsel_t     o_rm,
    output logic [1:0]  o_sh,
    output logic [1:0]  o_op,
    output logic [15:0] o_sximm8,
    output iclass_t     o_iclass
);

    logic [2:0] w_opcode;

    assign w_opcode = i_ir[15:13];
    assign o_op     = i_ir[12:11];
    assign o_rn     = i_ir[10:8];
    assign o_rd     = i_ir[7:5];
    assign o_sh     = i_ir[4:3];
    assign o_rm     = i_ir[2:0];
    assign o_sximm8 = {{8{i_ir[7]}}, i_ir[7:0]};

    always_comb begin
        o_iclass = IC_UNDEF;
        if (w_opcode == OPC_MOV && o_op == OP_MOVI)
            o_iclass = IC_MOVI;
        else if (w_opcode == OPC_MOV && o_op == OP_MOVR)
            o_iclass = IC_MOVR;
        else if (w_opcode == OPC_ALU) begin
            case (o_op)
                OP_ADD:  o_iclass = IC_ADD;
                OP_CMP:  o_iclass = IC_CMP;
                OP_AND:  o_iclass = IC_AND;
                default: o_iclass = IC_MVN;
            endcase
        end
    end

endmodule

// File: rtl/instr_controller.sv
// Instruction register plus Moore sequencer driving the register/ALU datapath controls.
module instr_controller
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in,
    input  logic        load,
    input  logic        s,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        write,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] datapath_in,
    output logic        w,
    output logic        illegal
);

    logic [15:0] r_ir;
    state_t      r_state;
    state_t      w_next;
    regsel_t     w_rn, w_rd, w_rm, w_sel;
    logic [1:0]  w_sh, w_op;
    logic [15:0] w_sximm8;
    iclass_t     w_iclass;

    instr_decoder u_dec (
        .i_ir     (r_ir),
        .o_rn     (w_rn),
        .o_rd     (w_rd),
        .o_rm     (w_rm),
        .o_sh     (w_sh),
        .o_op     (w_op),
        .o_sximm8 (w_sximm8),
        .o_iclass (w_iclass)
    );

    // IR only loads in WAIT, so it is frozen for the rest of the instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_WAIT;
            r_ir    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_WAIT && load)
                r_ir <= in;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_sel   = '0;
        vsel    = 1'b0;
        loada   = 1'b0;
        loadb   = 1'b0;
        loadc   = 1'b0;
        loads   = 1'b0;
        write   = 1'b0;
        asel    = 1'b0;
        shift   = 2'b00;
        ALUop   = ALU_ADD;
        w       = 1'b0;
        illegal = 1'b0;
        case (r_state)
            S_WAIT: begin
                w = 1'b1;
                if (s) w_next = S_DECODE;
            end
            S_DECODE: begin
                case (w_iclass)
                    IC_MOVI:               w_next = S_WRITE_IMM;
                    IC_MOVR, IC_MVN:       w_next = S_GET_B;
                    IC_ADD, IC_AND, IC_CMP: w_next = S_GET_A;
                    default: begin
                        w_next  = S_WAIT;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_WRITE_IMM: begin
                w_sel  = w_rn;
                vsel   = 1'b1;
                write  = 1'b1;
                w_next = S_WAIT;
            end
            S_GET_A: begin
                w_sel  = w_rn;
                loada  = 1'b1;
                w_next = S_GET_B;
            end
            S_GET_B: begin
                w_sel  = w_rm;
                loadb  = 1'b1;
                w_next = (w_iclass == IC_CMP) ? S_CMP : S_ALU;
            end
            S_ALU: begin
                shift  = w_sh;
                loadc  = 1'b1;
                // MOV reg passes the shifted B through by adding it to a zeroed A
                if (w_iclass == IC_MOVR) begin
                    asel  = 1'b1;
                    ALUop = ALU_ADD;
                end else begin
                    ALUop = w_op;
                end
                w_next = S_WRITE_REG;
            end
            S_CMP: begin
                shift  = w_sh;
                ALUop  = ALU_SUB;
                loads  = 1'b1;
                w_next = S_WAIT;
            end
            S_WRITE_REG: begin
                w_sel  = w_rd;
                write  = 1'b1;
                w_next = S_WAIT;
            end
            default: w_next = S_WAIT;
        endcase
    end

    assign readnum     = w_sel;
    assign writenum    = w_sel;
    assign bsel        = 1'b0;
    assign datapath_in = w_sximm8;

endmodule

// File: tb/tb_instr_controller.sv
// Self-checking bench: per-instruction expected control traces built from the ISA rules.
module tb_instr_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in;
    logic        load, s;
    logic [2:0]  readnum, writenum;
    logic        vsel, loada, loadb, loadc, loads, write, asel, bsel;
    logic [1:0]  shift, ALUop;
    logic [15:0] datapath_in;
    logic        w, illegal;

    instr_controller dut (
        .clk(clk), .reset(reset), .in(in), .load(load), .s(s),
        .readnum(readnum), .writenum(writenum), .vsel(vsel),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .write(write), .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop),
        .datapath_in(datapath_in), .w(w), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] rn;
        logic [2:0] wn;
        logic       vsel, la, lb, lc, ls, wr, asel, bsel;
        logic [1:0] sh;
        logic [1:0] alu;
        logic       w, ill;
    } ctl_t;

    int          checks = 0;
    int          errors = 0;
    ctl_t        exp_q[$];
    logic [15:0] m_ir;

    function automatic ctl_t sample();
        ctl_t c;
        c.rn = readnum; c.wn = writenum; c.vsel = vsel;
        c.la = loada; c.lb = loadb; c.lc = loadc; c.ls = loads; c.wr = write;
        c.asel = asel; c.bsel = bsel; c.sh = shift; c.alu = ALUop;
        c.w = w; c.ill = illegal;
        return c;
    endfunction

    function automatic ctl_t idle();
        ctl_t c = '0;
        c.w = 1'b1;
        return c;
    endfunction

    // Expected per-cycle controls from DECODE until the cycle before WAIT returns
    function automatic void build_trace(input logic [15:0] ir);
        ctl_t c;
        logic [2:0] opc = ir[15:13];
        logic [1:0] op  = ir[12:11];
        logic [2:0] rn = ir[10:8], rd = ir[7:5], rm = ir[2:0];
        logic [1:0] sh = ir[4:3];
        bit movi = (opc == 3'b110 && op == 2'b10);
        bit movr = (opc == 3'b110 && op == 2'b00);
        bit alu  = (opc == 3'b101);
        bit cmp  = alu && op == 2'b01;
        bit mvn  = alu && op == 2'b11;
        exp_q.delete();
        c = '0; c.ill = !(movi || movr || alu);
        exp_q.push_back(c);
        if (movi) begin
            c = '0; c.rn = rn; c.wn = rn; c.vsel = 1; c.wr = 1;
            exp_q.push_back(c);
        end
        if (alu && !mvn) begin
            c = '0; c.rn = rn; c.wn = rn; c.la = 1;
            exp_q.push_back(c);
        end
        if (alu || movr) begin
            c = '0; c.rn = rm; c.wn = rm; c.lb = 1;
            exp_q.push_back(c);
            c = '0; c.sh = sh;
            if (cmp) begin
                c.alu = 2'b01; c.ls = 1;
            end else begin
                c.lc = 1; c.asel = movr; c.alu = movr ? 2'b00 : op;
            end
            exp_q.push_back(c);
            if (!cmp) begin
                c = '0; c.rn = rd; c.wn = rd; c.wr = 1;
                exp_q.push_back(c);
            end
        end
    endfunction

    // mode 0: inputs quiet, 1: random load/s/in noise, 2: s held high
    task automatic run_instr(input logic [15:0] ir, input int mode, input bit do_load, input string tag);
        ctl_t obs;
        @(negedge clk);
        obs = sample();
        checks++;
        if (obs !== idle()) begin
            $display("FAIL %s wait_ready got=%h exp=%h", tag, obs, idle()); errors++;
        end
        if (do_load) m_ir = ir;
        in = ir; load = do_load; s = 1'b1;
        build_trace(m_ir);
        foreach (exp_q[i]) begin
            @(negedge clk);
            obs = sample();
            checks++;
            if (obs !== exp_q[i]) begin
                $display("FAIL %s step%0d ir=%h got=%h exp=%h", tag, i, m_ir, obs, exp_q[i]); errors++;
            end
            if (exp_q[i].wr && exp_q[i].vsel) begin
                checks++;
                if (datapath_in !== {{8{m_ir[7]}}, m_ir[7:0]}) begin
                    $display("FAIL %s sximm8 got=%h exp=%h", tag, datapath_in, {{8{m_ir[7]}}, m_ir[7:0]});
                    errors++;
                end
            end
            case (mode)
                1:       begin load = 1'($urandom); s = 1'($urandom); in = 16'($urandom); end
                2:       begin load = 1'b0; s = 1'b1; end
                default: begin load = 1'b0; s = 1'b0; end
            endcase
        end
    endtask

    task automatic test_reset();
        ctl_t obs;
        reset = 1'b1; load = 1'b0; s = 1'b0; in = 16'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_ir = 16'h0;
        @(negedge clk);
        obs = sample();
        checks++;
        if (obs !== idle() || datapath_in !== 16'h0) begin
            $display("FAIL reset_idle got=%h dp=%h exp=%h dp=0000", obs, datapath_in, idle()); errors++;
        end
        run_instr(16'h0, 0, 1'b0, "reset_ir0_illegal");
    endtask

    task automatic test_directed();
        run_instr(16'hD1FF, 0, 1'b1, "mov_imm");
        run_instr(16'hA148, 0, 1'b1, "add");
        run_instr(16'hA801, 0, 1'b1, "cmp");
        run_instr(16'hC07D, 0, 1'b1, "mov_reg");
        run_instr(16'hB8E2, 0, 1'b1, "mvn");
        run_instr(16'hD27F, 0, 1'b1, "mov_imm_pos");
        run_instr(16'hE000, 0, 1'b1, "undef");
    endtask

    task automatic test_ignore_inputs();
        logic [15:0] t = 16'hA148;
        in = 16'hD007;
        run_instr(t, 1, 1'b1, "noise_add");
        run_instr(16'hB0A3, 1, 1'b1, "noise_and");
    endtask

    task automatic test_mid_reset();
        ctl_t obs;
        @(negedge clk);
        in = 16'hA148; load = 1'b1; s = 1'b1; m_ir = 16'hA148;
        build_trace(m_ir);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            obs = sample();
            checks++;
            if (obs !== exp_q[i]) begin
                $display("FAIL midrst_step%0d got=%h exp=%h", i, obs, exp_q[i]); errors++;
            end
            load = 1'b0; s = 1'b0;
        end
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            reset = 1'b0;
            obs = sample();
            checks++;
            if (obs !== idle() || datapath_in !== 16'h0) begin
                $display("FAIL midrst_wait%0d got=%h dp=%h exp=%h dp=0000", i, obs, datapath_in, idle());
                errors++;
            end
        end
        m_ir = 16'h0;
        run_instr(16'h0, 0, 1'b0, "midrst_ir_cleared");
    endtask

    task automatic test_back_to_back();
        run_instr(16'hA148, 2, 1'b1, "b2b_first");
        run_instr(16'h0, 2, 1'b0, "b2b_repeat");
        run_instr(16'hD3F0, 2, 1'b1, "b2b_movi");
        run_instr(16'hA8C2, 0, 1'b1, "b2b_cmp");
    endtask

    task automatic test_random();
        logic [15:0] r;
        for (int n = 0; n < 60; n++) begin
            r = 16'($urandom);
            if ($urandom_range(0, 9) < 8) r[15:13] = $urandom_range(0, 1) ? 3'b101 : 3'b110;
            run_instr(r, int'($urandom_range(0, 2)), 1'b1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_inputs();
        test_mid_reset();
        test_back_to_back();
        test_random();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
